// File: rtl/cdc_hs_pkg.sv
// Shared types and limits for the toggle request/acknowledge CDC channel.
package cdc_hs_pkg;

    localparam int unsigned CDC_SYNC_STAGES_MIN = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } cdc_state_e;

endpackage

// File: rtl/cdc_ack_sync.sv
// Multi-flop synchronizer for a single toggle line from a foreign clock domain.
module cdc_ack_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *)
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source-side end of a two-phase req/ack CDC channel: captures one word,
// toggles req_o, and waits for the resynchronized acknowledge toggle.
module cdc_hs_tx
    import cdc_hs_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             req_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ack_i,
    output logic             done_o,
    output logic             err_o
);

    if (SYNC_STAGES < CDC_SYNC_STAGES_MIN) begin : g_bad_sync_stages
        $error("cdc_hs_tx: SYNC_STAGES must be at least %0d", CDC_SYNC_STAGES_MIN);
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("cdc_hs_tx: WIDTH must be at least 1");
    end

    cdc_state_e       state_q, state_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ack_seen_q, ack_seen_d;
    logic             ack_s;
    logic             ack_toggle;
    logic             accept;

    cdc_ack_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (ack_i),
        .q_o   (ack_s)
    );

    assign ready_o    = (state_q == IDLE) & ~rst_i;
    assign accept     = valid_i & ready_o;
    assign ack_toggle = (ack_s != ack_seen_q);

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        data_d     = data_q;
        done_d     = 1'b0;
        err_d      = err_q;
        ack_seen_d = ack_seen_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = data_i;
                    req_d   = ~req_q;
                    state_d = WAIT;
                end
                // An ack with nothing outstanding is flagged and absorbed, so a
                // concurrently accepted word still waits for a fresh toggle.
                if (ack_toggle) begin
                    ack_seen_d = ack_s;
                    err_d      = 1'b1;
                end
            end
            WAIT: begin
                if (ack_toggle) begin
                    ack_seen_d = ack_s;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ack_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            data_q     <= data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ack_seen_q <= ack_seen_d;
        end
    end

    assign req_o  = req_q;
    assign data_o = data_q;
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Self-checking bench for cdc_hs_tx: directed vector table, corner sequences,
// and a randomized-phase scoreboard run on an 8-bit, 3-stage instance.
module tb_cdc_hs_tx;

    localparam int unsigned W  = 32;
    localparam int unsigned S  = 2;
    localparam int unsigned W8 = 8;
    localparam int unsigned S8 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, valid, ready, req, done, err, ack;
    logic [W-1:0]  din, dout;
    logic          r_valid, r_ready, r_req, r_done, r_err, r_ack;
    logic [W8-1:0] r_din, r_dout;

    cdc_hs_tx #(.WIDTH(W), .SYNC_STAGES(S)) u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid),
        .ready_o (ready),
        .data_i  (din),
        .req_o   (req),
        .data_o  (dout),
        .ack_i   (ack),
        .done_o  (done),
        .err_o   (err)
    );

    cdc_hs_tx #(.WIDTH(W8), .SYNC_STAGES(S8)) u_dut8 (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (r_valid),
        .ready_o (r_ready),
        .data_i  (r_din),
        .req_o   (r_req),
        .data_o  (r_dout),
        .ack_i   (r_ack),
        .done_o  (r_done),
        .err_o   (r_err)
    );

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept one word, toggle ack dly cycles after the req toggle, expect done
    // exactly SYNC_STAGES+1 edges after the ack change.
    task automatic send32(input logic [31:0] d, input int unsigned dly,
                          input logic exp_req, input string tag);
        int unsigned cnt;
        logic        held;
        check({tag, "_ready_before"}, ready, 1);
        valid = 1'b1;
        din   = d;
        tick();
        valid = 1'b0;
        din   = $urandom;
        check({tag, "_req"}, req, exp_req);
        check({tag, "_data"}, dout, d);
        check({tag, "_ready_wait"}, ready, 0);
        check({tag, "_done_early"}, done, 0);
        held = 1'b1;
        repeat (dly) begin
            tick();
            if (dout !== d || req !== exp_req || done !== 1'b0) held = 1'b0;
        end
        ack = ~ack;
        cnt = 0;
        do begin
            tick();
            cnt++;
            if (dout !== d || req !== exp_req) held = 1'b0;
        end while (done !== 1'b1 && cnt < 40);
        check({tag, "_done_latency"}, cnt, S + 1);
        check({tag, "_held"}, held, 1);
        check({tag, "_ready_after"}, ready, 1);
        tick();
        check({tag, "_done_width"}, done, 0);
    endtask

    typedef struct {
        logic [31:0] data;
        int unsigned ack_dly;
        logic        exp_req;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] hv[3];
        logic [7:0]  sb[$];
        logic [7:0]  exp8;
        logic        last_req, held;
        int unsigned cnt, n_done, n_xfer;

        vecs[0] = '{32'hDEADBEEF, 5,  1'b1};
        vecs[1] = '{32'h00000000, 1,  1'b0};
        vecs[2] = '{32'hFFFFFFFF, 12, 1'b1};
        vecs[3] = '{32'h0F0F0F0F, 3,  1'b0};
        hv[0] = 32'h1; hv[1] = 32'h2; hv[2] = 32'h3;

        rst = 1'b1; valid = 1'b0; din = '0; ack = 1'b0;
        r_valid = 1'b0; r_din = '0; r_ack = 1'b0;

        // Reset behaviour
        repeat (3) tick();
        check("rst_ready", ready, 0);
        check("rst_req", req, 0);
        check("rst_data", dout, 0);
        check("rst_err", err, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", ready, 1);
        tick();

        // Directed vector table
        for (int i = 0; i < 4; i++)
            send32(vecs[i].data, vecs[i].ack_dly, vecs[i].exp_req, $sformatf("vec%0d", i));

        // valid held high: three accepts in order, valid ignored in WAIT
        n_done   = 0;
        last_req = req;
        valid    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din = hv[k];
            cnt = 0;
            while (req === last_req && cnt < 40) begin
                tick();
                cnt++;
                if (done === 1'b1) n_done++;
            end
            check($sformatf("hv%0d_accept", k), req !== last_req, 1);
            last_req = req;
            check($sformatf("hv%0d_data", k), dout, hv[k]);
            if (k < 2) din = hv[k+1];
            else begin
                din   = 32'hBAD0BAD0;
                valid = 1'b0;
            end
            held = 1'b1;
            repeat ($urandom_range(1, 20)) begin
                tick();
                if (dout !== hv[k] || req !== last_req) held = 1'b0;
                if (done === 1'b1) n_done++;
            end
            check($sformatf("hv%0d_held", k), held, 1);
            ack = ~ack;
            cnt = 0;
            do begin tick(); cnt++; end while (done !== 1'b1 && cnt < 40);
            if (done === 1'b1) n_done++;
        end
        repeat (5) tick();
        check("hv_done_count", n_done, 3);
        check("hv_req_final", req, 1);

        // Spurious ack while IDLE
        ack = ~ack;
        repeat (4) tick();
        check("spur_err", err, 1);
        check("spur_ready", ready, 1);
        check("spur_done", done, 0);
        send32(32'h55, 10, 1'b0, "spur_send");
        check("spur_err_sticky", err, 1);

        // Reset while WAIT aborts the transfer
        valid = 1'b1;
        din   = 32'h12345678;
        tick();
        valid = 1'b0;
        tick();
        rst = 1'b1;
        ack = 1'b0;
        tick();
        check("wrst_ready_in_rst", ready, 0);
        rst = 1'b0;
        #1;
        check("wrst_req", req, 0);
        check("wrst_data", dout, 0);
        check("wrst_err", err, 0);
        held = 1'b1;
        repeat (8) begin
            tick();
            if (done !== 1'b0) held = 1'b0;
        end
        check("wrst_no_done", held, 1);
        send32(32'hA5A5A5A5, 4, 1'b1, "wrst_send");
        check("wrst_err_after", err, 0);

        // Randomized async ack phase, scoreboarded
        n_xfer = 0;
        for (int t = 0; t < 1000; t++) begin
            repeat ($urandom_range(0, 2)) tick();
            r_din   = 8'($urandom);
            r_valid = 1'b1;
            sb.push_back(r_din);
            last_req = r_req;
            cnt = 0;
            while (r_req === last_req && cnt < 40) begin
                tick();
                cnt++;
            end
            check("rnd_accept", r_req !== last_req, 1);
            exp8 = sb.pop_front();
            check("rnd_data", r_dout, exp8);
            if ($urandom_range(0, 1) == 1) r_din = 8'($urandom);
            else r_valid = 1'b0;
            held = 1'b1;
            repeat ($urandom_range(0, 5)) begin
                tick();
                if (r_dout !== exp8 || r_req === last_req || r_done !== 1'b0) held = 1'b0;
            end
            #($urandom_range(0, 8));
            r_ack   = ~r_ack;
            r_valid = 1'b0;
            cnt = 0;
            do begin
                tick();
                cnt++;
                if (r_dout !== exp8) held = 1'b0;
            end while (r_done !== 1'b1 && cnt < 40);
            check("rnd_done_latency", cnt, S8 + 1);
            check("rnd_held", held, 1);
            if (r_done === 1'b1) n_xfer++;
        end
        check("rnd_xfer_count", n_xfer, 1000);
        check("rnd_err", r_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
